// File: rtl/demux_pkg.sv
// Shared constants, helper function and channel-index type for the
// 1-to-N stream demultiplexer.
package demux_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_NCH    = 4;

    // Ceiling log2 for elaboration-time widths; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int DEFAULT_SEL_W = clog2(DEFAULT_NCH);

    // Channel index for the default channel count.
    typedef logic [DEFAULT_SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel of the demux: a single-entry valid/data register.
// The slot is free when empty or when its word leaves this cycle, so a
// drain and a refill can happen on the same edge.
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Load takes priority over drain; a held word stays put until drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-NCH stream demultiplexer with unicast and broadcast.
//
// Handshake: a word moves on any edge where valid && ready are both high
// at that interface. in_ready never looks at in_valid; out_valid never
// drops or changes data while the matching out_ready is low.
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int NCH    = DEFAULT_NCH,
    localparam int SEL_W  = clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic                  err_sel
);

    logic [NCH-1:0] w_free;
    logic [NCH-1:0] w_load;
    logic           w_sel_ok;
    logic           w_in_ready;
    logic           w_xfer;
    logic           r_err_sel;

    assign w_sel_ok = (32'(in_sel) < NCH);

    // Accept decision: broadcast needs every slot free (never partial),
    // unicast needs only its target, out-of-range is always accepted and dropped.
    always_comb begin
        w_in_ready = 1'b1;
        if (in_bcast) begin
            w_in_ready = &w_free;
        end else if (w_sel_ok) begin
            w_in_ready = w_free[in_sel];
        end
    end

    assign in_ready = w_in_ready;
    assign w_xfer   = in_valid && w_in_ready;

    // Per-slot load enable; an out-of-range select matches no slot.
    always_comb begin
        w_load = '0;
        for (int k = 0; k < NCH; k++) begin
            w_load[k] = w_xfer && (in_bcast || (32'(in_sel) == k));
        end
    end

    // Sticky error: set when an out-of-range unicast word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_sel <= 1'b0;
        end else if (w_xfer && !in_bcast && !w_sel_ok) begin
            r_err_sel <= 1'b1;
        end
    end

    assign err_sel = r_err_sel;

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_data  (in_data),
            .i_ready (out_ready[g]),
            .o_valid (out_valid[g]),
            .o_data  (out_data[g*DATA_W +: DATA_W]),
            .o_free  (w_free[g])
        );
    end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: a 4-channel instance with a queue-based
// scoreboard, plus a 3-channel instance for out-of-range selects.
module tb_demux_1xn_stream;
    import demux_pkg::*;

    localparam int DW = 8;
    localparam int N4 = 4;
    localparam int N3 = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-channel instance
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data  = '0;
    ch_idx_t         in_sel   = '0;
    logic            in_bcast = 1'b0;
    logic [N4-1:0]   out_valid;
    logic [N4-1:0]   out_ready = '1;
    logic [N4*DW-1:0] out_data;
    logic            err_sel;

    // 3-channel instance
    logic            in3_valid = 1'b0;
    logic            in3_ready;
    logic [DW-1:0]   in3_data  = '0;
    logic [1:0]      in3_sel   = '0;
    logic            in3_bcast = 1'b0;
    logic [N3-1:0]   out3_valid;
    logic [N3-1:0]   out3_ready = '1;
    logic [N3*DW-1:0] out3_data;
    logic            err3;

    demux_1xn_stream #(.DATA_W(DW), .NCH(N4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_sel(err_sel)
    );

    demux_1xn_stream #(.DATA_W(DW), .NCH(N3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data),
        .in_sel(in3_sel), .in_bcast(in3_bcast),
        .out_valid(out3_valid), .out_ready(out3_ready), .out_data(out3_data),
        .err_sel(err3)
    );

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q [N4][$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    // Each channel is a capacity-one queue in the model: the head is the
    // word the consumer must see, and it leaves when out_ready is high.
    logic [N4-1:0] mon_vld;
    logic [N4-1:0] mon_free;
    logic          mon_rdy;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < N4; k++) begin
                mon_vld[k]  = (exp_q[k].size() != 0);
                mon_free[k] = !mon_vld[k] || out_ready[k];
            end
            mon_rdy = in_bcast ? (&mon_free) : mon_free[in_sel];
            check("in_ready", 32'(in_ready), 32'(mon_rdy));
            check("out_valid", 32'(out_valid), 32'(mon_vld));
            check("err_sel4", 32'(err_sel), 32'd0);
            for (int k = 0; k < N4; k++) begin
                if (mon_vld[k]) begin
                    check($sformatf("ch%0d_data", k), 32'(out_data[k*DW +: DW]), 32'(exp_q[k][0]));
                end
            end
            for (int k = 0; k < N4; k++) begin
                if (mon_vld[k] && out_ready[k]) void'(exp_q[k].pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle on the 4-channel instance. Inputs change just after the
    // rising edge; after the monitor has retired drained words, a slot is
    // free exactly when its queue is empty, which decides acceptance.
    task automatic cycle4(input logic v, input logic b, input ch_idx_t s,
                          input logic [DW-1:0] d, input logic [N4-1:0] ordy,
                          output bit acc);
        bit all_empty;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_bcast  = b;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
        #1;
        all_empty = 1'b1;
        for (int k = 0; k < N4; k++) if (exp_q[k].size() != 0) all_empty = 1'b0;
        acc = v && (b ? all_empty : (exp_q[s].size() == 0));
        if (acc) begin
            if (b) for (int k = 0; k < N4; k++) exp_q[k].push_back(d);
            else exp_q[s].push_back(d);
        end
    endtask

    task automatic drive_word(input logic b, input ch_idx_t s, input logic [DW-1:0] d,
                              input logic [N4-1:0] ordy, input int max_cycles);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < max_cycles && !acc; i++) cycle4(1'b1, b, s, d, ordy, acc);
    endtask

    task automatic idle4(input logic [N4-1:0] ordy, input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle4(1'b0, 1'b0, '0, '0, ordy, acc);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        bit acc;
        in_bcast = 1'b1;
        #2;
        // in reset: outputs cleared, in_ready still combinational
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err_sel", 32'(err_sel), 32'd0);
        check("rst_in_ready_bcast", 32'(in_ready), 32'd1);
        check("rst_err3", 32'(err3), 32'd0);
        in_bcast = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        mon_en = 1'b1;

        // unicast A5 to channel 2
        drive_word(1'b0, 2'd2, 8'hA5, 4'b1111, 4);
        idle4(4'b1111, 2);

        // backpressure on channel 1
        drive_word(1'b0, 2'd1, 8'h11, 4'b1101, 4);
        drive_word(1'b0, 2'd1, 8'h22, 4'b1101, 3);
        drive_word(1'b0, 2'd1, 8'h22, 4'b1111, 4);
        idle4(4'b1111, 2);

        // broadcast blocked by full channel 3
        drive_word(1'b0, 2'd3, 8'h77, 4'b0111, 4);
        drive_word(1'b1, 2'd0, 8'h3C, 4'b0111, 3);
        drive_word(1'b1, 2'd0, 8'h3C, 4'b1111, 4);
        idle4(4'b1111, 2);

        // streaming 0..7 to channel 0
        for (int i = 0; i < 8; i++) drive_word(1'b0, 2'd0, 8'(i), 4'b1111, 4);
        idle4(4'b1111, 2);

        // out-of-range select on the 3-channel instance
        @(posedge clk); #1;
        in3_valid = 1'b1; in3_sel = 2'd3; in3_data = 8'hFF; in3_bcast = 1'b0;
        @(negedge clk);
        check("oor_in_ready", 32'(in3_ready), 32'd1);
        check("oor_err_before", 32'(err3), 32'd0);
        @(posedge clk); #1;
        in3_valid = 1'b0;
        @(negedge clk);
        check("oor_err_set", 32'(err3), 32'd1);
        check("oor_no_valid", 32'(out3_valid), 32'd0);
        @(posedge clk); #1;
        in3_valid = 1'b1; in3_sel = 2'd1; in3_data = 8'h42;
        @(negedge clk);
        check("n3_in_ready", 32'(in3_ready), 32'd1);
        @(posedge clk); #1;
        in3_bcast = 1'b1; in3_data = 8'h99;
        @(negedge clk);
        check("n3_valid_uni", 32'(out3_valid), 32'b010);
        check("n3_data_uni", 32'(out3_data[15:8]), 32'h42);
        check("n3_err_sticky1", 32'(err3), 32'd1);
        @(posedge clk); #1;
        in3_valid = 1'b0; in3_bcast = 1'b0;
        @(negedge clk);
        check("n3_valid_bcast", 32'(out3_valid), 32'b111);
        check("n3_data_bcast", out3_data, 32'h999999);
        check("n3_err_sticky2", 32'(err3), 32'd1);

        // randomized traffic on the 4-channel instance
        for (int i = 0; i < 400; i++) begin
            cycle4(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   ch_idx_t'($urandom_range(0, 3)), 8'($urandom),
                   4'($urandom_range(0, 15)), acc);
        end
        idle4(4'b1111, 2);

        // async reset with channels 0 and 2 holding words
        drive_word(1'b0, 2'd0, 8'h5A, 4'b1010, 4);
        drive_word(1'b0, 2'd2, 8'hC3, 4'b1010, 4);
        idle4(4'b1010, 1);
        @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(out_valid), 32'b0101);
        check("pre_rst_err3", 32'(err3), 32'd1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_err3", 32'(err3), 32'd0);
        check("async_rst_valid3", 32'(out3_valid), 32'd0);
        for (int k = 0; k < N4; k++) exp_q[k].delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        mon_en = 1'b1;
        idle4(4'b1111, 3);
        check("post_rst_err3", 32'(err3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
